sram_ctrl_param: RTL and testbench
==================================

// Module: sram_ctrl_param
// PURPOSE
//  Parametrised single-port async-SRAM controller between the MEM stage and the external 32-bit SRAM.
//  Replaces the fixed-timing controller: req/ack handshake, registered SRAM pins, programmable read/write
//  wait states, byte-lane steering from the byte address, and alignment error reporting.
// PARAMETERS
//  ADDR_W   20  SRAM word-address width; CPU byte address is ADDR_W+2 bits
//  RD_WAIT  2   cycles CE_n/OE_n held low per read (>=1); data sampled on last edge
//  WR_WAIT  1   cycles WE_n held low per write (>=1)
// PORTS
//  clk50       in   1         system clock
//  rst         in   1         asynchronous, active-high reset
//  req_i       in   1         request; held high until ack_o seen
//  op_i        in   4         `MEM_LB/LBU/LH/LHU/LW/SB/SH/SW codes from defines.v
//  addr_i      in   ADDR_W+2  byte address
//  wdata_i     in   32        store data, right-aligned (byte in [7:0], half in [15:0])
//  rdata_o     out  32        load result, extended per op; valid only while ack_o=1
//  ack_o       out  1         one-cycle completion pulse
//  err_o       out  1         with ack_o: misaligned address or unknown op; no SRAM access made
//  busy_o      out  1         high from accept to ack inclusive
//  sram_addr_o out  ADDR_W    addr_i[ADDR_W+1:2], latched at accept
//  sram_ce_n_o out  1         chip enable, active low
//  sram_oe_n_o out  1         output enable, active low
//  sram_we_n_o out  1         write enable, active low
//  sram_be_n_o out  4         byte enables, active low, lane k = data[8k+7:8k]
//  sram_data_io inout 32      SRAM data bus; driven only in WR_SETUP/WR_PULSE/WR_HOLD
// BEHAVIOUR
//  - Reset (async): state IDLE, ack/err/busy=0, rdata=0, ce_n/oe_n/we_n=1, be_n=4'hF, addr=0, bus Z.
//    Reset mid-transaction aborts immediately; no ack is ever issued for the aborted request.
//  - All outputs registered. op/addr/wdata latched at the accepting edge; later changes ignored.
//  - Accept: edge in IDLE with req_i=1. req_i sampled only in IDLE; ignored in DONE, so the master must
//    drop req_i in the ack cycle or a new transaction starts on the following IDLE edge.
//  - Lanes (little-endian): byte off=addr[1:0] -> lane off; half addr[1]=h -> lanes {2h+1,2h}; word all.
//    Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Violation or unknown op -> ERR.
//  - States: IDLE -> RD | WR_SETUP | ERR on accept.
//    RD: ce_n=oe_n=0, be_n=0000, bus Z, RD_WAIT cycles (down-counter); on last edge capture lane(s),
//        extend (LB/LH sign, LBU/LHU zero), -> DONE.
//    WR_SETUP: ce_n=0, we_n=1, oe_n=1, be_n per lanes, wdata replicated to every lane, bus driven; 1 cycle.
//    WR_PULSE: as WR_SETUP with we_n=0, WR_WAIT cycles. WR_HOLD: we_n=1, data+be held 1 cycle -> DONE.
//    ERR: pins idle, 1 cycle -> DONE with err_o=1.  DONE: pins idle, bus Z, ack_o=1 one cycle -> IDLE.
//  - Latency accept edge to ack cycle: read RD_WAIT+1, write WR_WAIT+3, error 2 cycles.
//  - oe_n never low while bus driven; we_n never low with ce_n high; be_n=1111 whenever ce_n=1.
//  - Wait counter width $clog2(max(RD_WAIT,WR_WAIT)+1).
// STRUCTURE
//  - `MEM_* op codes stay in defines.v (shared); state encodings are local parameters.
//  - Sub-module sram_lane_steer (combinational): op+addr[1:0] -> be_n, misalign flag, store replication,
//    load extraction/extension. FSM, counter and pin registers live in sram_ctrl_param.
// TESTING
//  - SW addr 0x00010, wdata 0xDEADBEEF -> sram_addr=0x00004, be_n=0000 during WE pulse, ack at cycle 4 (WR_WAIT=1).
//  - SB addr 0x3, wdata 0x000000A5 -> be_n=0111, bus 0xA5A5A5A5; then LB addr 0x3 -> rdata 0xFFFFFFA5, LBU 0x000000A5.
//  - SRAM model holds 0x80017FFF; LH addr 2 -> 0xFFFF8001, LHU addr 0 -> 0x00007FFF, ack 3 cycles after accept.
//  - LW addr 0x2 / SH addr 0x1 -> err_o=ack_o=1 at cycle 2, ce_n stays 1 throughout.
//  - Back-to-back: req held through ack -> second transaction accepted exactly one cycle after ack, no overlap.
//  - Assert rst during WR_PULSE -> we_n/ce_n=1 and bus Z same cycle, no ack; next request completes normally.

Source files
------------

// File: rtl/sram_ctrl_param_pkg.sv
// sram_ctrl_param_pkg: memory op codes and controller state encoding shared by the SRAM controller
package sram_ctrl_param_pkg;
    localparam logic [3:0] MEM_LB  = 4'd0;
    localparam logic [3:0] MEM_LBU = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LHU = 4'd3;
    localparam logic [3:0] MEM_LW  = 4'd4;
    localparam logic [3:0] MEM_SB  = 4'd5;
    localparam logic [3:0] MEM_SH  = 4'd6;
    localparam logic [3:0] MEM_SW  = 4'd7;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ERR, DONE} state_t;
endpackage

// File: rtl/sram_lane_steer.sv
// sram_lane_steer: byte-lane enables, alignment check, store replication and load extension
module sram_lane_steer
    import sram_ctrl_param_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rbus,
    output logic [3:0]  be_n,
    output logic        bad,
    output logic        store,
    output logic [31:0] wrep,
    output logic [31:0] rext
);
    logic byte_op, half_op, word_op, sgn;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        byte_op = op == MEM_LB || op == MEM_LBU || op == MEM_SB;
        half_op = op == MEM_LH || op == MEM_LHU || op == MEM_SH;
        word_op = op == MEM_LW || op == MEM_SW;
        store   = op == MEM_SB || op == MEM_SH || op == MEM_SW;
        sgn     = op == MEM_LB || op == MEM_LH;
        bad     = !(byte_op || half_op || word_op) || (half_op && off[0]) || (word_op && off != 2'd0);
        be_n    = ~(byte_op ? 4'b0001 << off : half_op ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111);
        wrep    = byte_op ? {4{wdata[7:0]}} : half_op ? {2{wdata[15:0]}} : wdata;
        b       = 8'(rbus >> {off, 3'b000});
        h       = off[1] ? rbus[31:16] : rbus[15:0];
        rext    = byte_op ? {{24{sgn & b[7]}}, b} : half_op ? {{16{sgn & h[15]}}, h} : rbus;
    end
endmodule

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: req/ack async-SRAM controller with registered pins and programmable wait states
module sram_ctrl_param
    import sram_ctrl_param_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              req_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W+1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    inout  wire  [31:0]       sram_data_io
);
    localparam int CW = $clog2((RD_WAIT > WR_WAIT ? RD_WAIT : WR_WAIT) + 1);
    localparam logic [CW-1:0] RD_LD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LD = CW'(WR_WAIT - 1);
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]  op_q, op_s, be_s;
    logic [1:0]  off_q, off_s;
    logic        bad, store, drive, wr_nxt;
    logic [31:0] wrep, rext, dout;
    // in IDLE the steer sees the live request so accept-edge pin values are ready
    assign op_s         = state == IDLE ? op_i : op_q;
    assign off_s        = state == IDLE ? addr_i[1:0] : off_q;
    assign wr_nxt       = nxt inside {WR_SETUP, WR_PULSE, WR_HOLD};
    assign sram_data_io = drive ? dout : 'z;
    sram_lane_steer u_steer (
        .op(op_s), .off(off_s), .wdata(wdata_i), .rbus(sram_data_io),
        .be_n(be_s), .bad(bad), .store(store), .wrep(wrep), .rext(rext)
    );
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (req_i) begin
                nxt     = bad ? ERR : store ? WR_SETUP : RD;
                cnt_nxt = RD_LD;
            end
            RD: begin
                nxt     = cnt == '0 ? DONE : RD;
                cnt_nxt = cnt - 1'b1;
            end
            WR_SETUP: begin
                nxt     = WR_PULSE;
                cnt_nxt = WR_LD;
            end
            WR_PULSE: begin
                nxt     = cnt == '0 ? WR_HOLD : WR_PULSE;
                cnt_nxt = cnt - 1'b1;
            end
            WR_HOLD, ERR: nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    // every pin is registered from the next state so it changes cleanly with the state
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            off_q       <= '0;
            dout        <= '0;
            drive       <= 1'b0;
            rdata_o     <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            sram_addr_o <= '0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_be_n_o <= 4'hF;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_i) begin
                op_q        <= op_i;
                off_q       <= addr_i[1:0];
                sram_addr_o <= addr_i[ADDR_W+1:2];
                dout        <= wrep;
            end
            if (state == RD && nxt == DONE) rdata_o <= rext;
            ack_o       <= nxt == DONE;
            err_o       <= nxt == DONE && state == ERR;
            busy_o      <= nxt != IDLE;
            drive       <= wr_nxt;
            sram_ce_n_o <= !(wr_nxt || nxt == RD);
            sram_oe_n_o <= nxt != RD;
            sram_we_n_o <= nxt != WR_PULSE;
            sram_be_n_o <= nxt == RD ? 4'h0 : wr_nxt ? be_s : 4'hF;
        end
    end
endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb_sram_ctrl_param: table, random and corner-case checks of sram_ctrl_param against a byte-array memory model
module tb_sram_ctrl_param;
    import sram_ctrl_param_pkg::*;
    localparam int AW = 20, RDW = 2, WRW = 1;
    logic clk50 = 1'b0, rst = 1'b1, req = 1'b0;
    logic [3:0]    op = '0;
    logic [AW+1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ack, err, busy, ce_n, oe_n, we_n;
    logic [AW-1:0] s_addr;
    logic [3:0]    be_n;
    wire  [31:0]   s_bus;
    logic [31:0]   mem [64];
    logic [7:0]    rb [256];
    int checks = 0, fails = 0;
    logic ce_seen;
    logic [3:0]    we_be;
    logic [31:0]   we_bus;
    logic [AW-1:0] we_addr;

    always #10 clk50 = ~clk50;

    sram_ctrl_param #(.ADDR_W(AW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .clk50(clk50), .rst(rst), .req_i(req), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .ack_o(ack), .err_o(err), .busy_o(busy), .sram_addr_o(s_addr),
        .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_be_n_o(be_n),
        .sram_data_io(s_bus)
    );

    // external async SRAM: drives on CE+OE, latches enabled lanes on the rising WE edge
    assign s_bus = (!ce_n && !oe_n) ? mem[s_addr[5:0]] : 'z;
    always @(posedge we_n)
        if (!ce_n)
            for (int k = 0; k < 4; k++)
                if (!be_n[k]) mem[s_addr[5:0]][8*k +: 8] <= s_bus[8*k +: 8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk50) if (!rst) begin
        check("we_without_ce", 32'(!we_n && ce_n), 0);
        check("be_while_deselected", 32'(ce_n && be_n != 4'hF), 0);
        check("oe_with_we", 32'(!oe_n && !we_n), 0);
        if (!ce_n) ce_seen = 1'b1;
        if (!we_n) begin
            we_be   = be_n;
            we_bus  = s_bus;
            we_addr = s_addr;
        end
    end

    function automatic int op_size(input logic [3:0] o);
        case (o)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [3:0] o);
        return o == MEM_SB || o == MEM_SH || o == MEM_SW;
    endfunction

    function automatic bit ref_err(input logic [3:0] o, input int a);
        return op_size(o) == 0 || (a % op_size(o)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] o, input int a);
        int sz = op_size(o);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v |= 32'(rb[a+i]) << (8*i);
        if ((o == MEM_LB || o == MEM_LH) && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8*sz);
        return v;
    endfunction

    task automatic ref_store(input logic [3:0] o, input int a, input logic [31:0] d);
        for (int i = 0; i < op_size(o); i++) rb[a+i] = d[8*i +: 8];
    endtask

    // one transaction: lat counts edges from the accepting edge to the ack cycle
    task automatic do_op(input logic [3:0] o, input int a, input logic [31:0] d,
                         output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk50);
        op = o; addr = (AW+2)'(a); wdata = d; req = 1'b1; ce_seen = 1'b0; lat = 0;
        do begin
            @(posedge clk50); #1;
            lat++;
            op = 4'($urandom); addr = (AW+2)'($urandom); wdata = $urandom;
            check("busy_in_flight", 32'(busy), 1);
        end while (!ack && lat < 30);
        check("ack_seen", 32'(ack), 1);
        req = 1'b0; rd = rdata; e = err;
        if (is_store(o) && !ref_err(o, a)) ref_store(o, a, d);
        @(posedge clk50); #1;
        check("ack_one_cycle", 32'(ack), 0);
        check("idle_after_ack", 32'(busy), 0);
    endtask

    typedef struct {
        logic [3:0]  op;
        int          addr;
        logic [31:0] wd;
        int          kind;
        int          lat;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] bus;
    } vec_t;
    vec_t v[12];

    initial begin
        logic [31:0] rd, exp_rd;
        logic e, exp_e;
        int lat, n, a, r;
        logic [3:0] o;
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic e, exp_e;
        int lat, n, a, r;
        logic [3:0] o;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) rb[i] = '0;
        // kind: 0 load, 1 store, 2 error
        v[0]  = '{MEM_SW,  'h10, 32'hDEADBEEF, 1, 4, 32'h0,        4'h0, 32'hDEADBEEF};
        v[1]  = '{MEM_SB,  'h3,  32'h000000A5, 1, 4, 32'h0,        4'h7, 32'hA5A5A5A5};
        v[2]  = '{MEM_LB,  'h3,  32'h0,        0, 3, 32'hFFFFFFA5, 4'h0, 32'h0};
        v[3]  = '{MEM_LBU, 'h3,  32'h0,        0, 3, 32'h000000A5, 4'h0, 32'h0};
        v[4]  = '{MEM_SW,  'h0,  32'h80017FFF, 1, 4, 32'h0,        4'h0, 32'h80017FFF};
        v[5]  = '{MEM_LH,  'h2,  32'h0,        0, 3, 32'hFFFF8001, 4'h0, 32'h0};
        v[6]  = '{MEM_LHU, 'h0,  32'h0,        0, 3, 32'h00007FFF, 4'h0, 32'h0};
        v[7]  = '{MEM_LW,  'h2,  32'h0,        2, 2, 32'h0,        4'h0, 32'h0};
        v[8]  = '{MEM_SH,  'h1,  32'h1234,     2, 2, 32'h0,        4'h0, 32'h0};
        v[9]  = '{4'hF,    'h0,  32'h0,        2, 2, 32'h0,        4'h0, 32'h0};
        v[10] = '{MEM_SH,  'h6,  32'h1234ABCD, 1, 4, 32'h0,        4'h3, 32'hABCDABCD};
        v[11] = '{MEM_LW,  'h4,  32'h0,        0, 3, 32'hABCD0000, 4'h0, 32'h0};

        repeat (2) @(posedge clk50);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdata", rdata, 0);
        check("rst_pins", {ce_n, oe_n, we_n, be_n}, 7'h7F);
        check("rst_addr", 32'(s_addr), 0);
        @(negedge clk50);
        rst = 1'b0;

        foreach (v[i]) begin
            do_op(v[i].op, v[i].addr, v[i].wd, rd, e, lat);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(v[i].kind == 2));
            check($sformatf("vec%0d_latency", i), lat, v[i].lat);
            if (v[i].kind == 0) check($sformatf("vec%0d_rdata", i), rd, v[i].rd);
            if (v[i].kind == 1) begin
                check($sformatf("vec%0d_be_pulse", i), 32'(we_be), 32'(v[i].be));
                check($sformatf("vec%0d_bus_pulse", i), we_bus, v[i].bus);
                check($sformatf("vec%0d_sram_addr", i), 32'(we_addr), v[i].addr >> 2);
            end
            if (v[i].kind == 2) check($sformatf("vec%0d_ce_touched", i), 32'(ce_seen), 0);
        end

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            o = r < 8 ? 4'(r) : 4'($urandom_range(8, 15));
            a = $urandom_range(0, 255);
            if (op_size(o) > 1 && $urandom_range(0, 3) != 0) a = a & ~(op_size(o) - 1);
            exp_e  = ref_err(o, a);
            exp_rd = ref_load(o, a);
            do_op(o, a, $urandom, rd, e, lat);
            check("rand_err", 32'(e), 32'(exp_e));
            check("rand_latency", lat, exp_e ? 2 : is_store(o) ? WRW + 3 : RDW + 1);
            if (!exp_e && !is_store(o)) check("rand_rdata", rd, exp_rd);
        end

        // back-to-back: req held through ack starts the next access one idle cycle later
        @(negedge clk50);
        op = MEM_SW; addr = 'h8; wdata = 32'hCAFEF00D; req = 1'b1; n = 0;
        do begin @(posedge clk50); #1; n++; end while (!ack && n < 30);
        check("b2b_first_ack", 32'(ack), 1);
        ref_store(MEM_SW, 'h8, 32'hCAFEF00D);
        op = MEM_LW;
        @(posedge clk50); #1;
        check("b2b_gap_busy", 32'(busy), 0);
        check("b2b_gap_ack", 32'(ack), 0);
        @(posedge clk50); #1;
        check("b2b_second_accepted", 32'(busy), 1);
        req = 1'b0; n = 1;
        while (!ack && n < 30) begin @(posedge clk50); #1; n++; end
        check("b2b_second_latency", n, RDW + 1);
        check("b2b_second_rdata", rdata, ref_load(MEM_LW, 'h8));
        @(posedge clk50); #1;

        // reset in the write pulse aborts at once with no ack
        @(negedge clk50);
        op = MEM_SW; addr = 'h30; wdata = 32'h12345678; req = 1'b1; n = 0;
        while (we_n && n < 30) begin @(negedge clk50); n++; end
        check("reach_we_pulse", 32'(we_n), 0);
        #3;
        rst = 1'b1; req = 1'b0;
        #1;
        check("abort_pins", {ce_n, oe_n, we_n, be_n}, 7'h7F);
        check("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk50); #1;
            check("abort_no_ack", 32'(ack), 0);
        end
        @(negedge clk50);
        rst = 1'b0;
        check("abort_rdata_cleared", rdata, 0);
        exp_rd = ref_load(MEM_LW, 'h10);
        do_op(MEM_LW, 'h10, 0, rd, e, lat);
        check("after_abort_err", 32'(e), 0);
        check("after_abort_latency", lat, RDW + 1);
        check("after_abort_rdata", rd, exp_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
